// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared receiver-control types and constants
// Purpose: FSM state encoding, phase count, default symbol counts and the
//          accumulator error width shared by the timing-search block.
package rx_ctrl_pkg;

  localparam int ERR_W            = 56;
  localparam int NUM_PHASES       = 4;
  localparam int DEF_SETTLE_SYMS  = 32;
  localparam int DEF_TIMEOUT_SYMS = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_PHASE,
    S_SETTLE,
    S_CLEAR,
    S_MEASURE,
    S_COMPARE,
    S_LOCKED
  } state_t;

endpackage

// File: rtl/symbol_timing_search_if.sv
// rtl/symbol_timing_search_if.sv - error accumulator handshake bundle
// Purpose: groups the accumulator clear/done handshake and its I/Q error results.
// Ports:   acc_clear (controller -> accumulator), acc_done, acc_err_i, acc_err_q
//          (accumulator -> controller). master = controller, slave = accumulator.
interface symbol_timing_search_if #(
  parameter int ERR_W = rx_ctrl_pkg::ERR_W
);
  logic             acc_clear;
  logic             acc_done;
  logic [ERR_W-1:0] acc_err_i;
  logic [ERR_W-1:0] acc_err_q;

  modport master (output acc_clear, input acc_done, input acc_err_i, input acc_err_q);
  modport slave  (input acc_clear, output acc_done, output acc_err_i, output acc_err_q);
endinterface

// File: rtl/sym_counter.sv
// rtl/sym_counter.sv - enable-gated up-counter with terminal-count detect
// Purpose: counts enables after a sync clear; flags the enable that reaches TC.
// Ports:   clk, reset (sync, active-high), i_clear (sync clear), i_ena (count
//          enable), o_tc_hit (high on the enable that makes count == TC).
module sym_counter #(
  parameter int TC    = 32,
  parameter int CNT_W = $clog2(TC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_ena,
  output logic o_tc_hit
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_ena) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Combinational so the owner can act on the same clk as the final enable.
  assign o_tc_hit = i_ena && (r_count == CNT_W'(TC - 1));

endmodule

// File: rtl/symbol_timing_search.sv
// rtl/symbol_timing_search.sv - downsampler phase acquisition controller
// Purpose: sweeps ds_del over all phases, measures the accumulated I+Q slicer
//          error per phase and locks onto the phase with minimum error.
// Ports:   clk, reset (sync, active-high), sym_clk_ena (symbol enable),
//          start (search pulse), acc (accumulator handshake, master side),
//          ds_del (phase select), busy, locked, fail, best_metric.
module symbol_timing_search
  import rx_ctrl_pkg::*;
#(
  parameter int ERR_W        = rx_ctrl_pkg::ERR_W,
  parameter int SETTLE_SYMS  = rx_ctrl_pkg::DEF_SETTLE_SYMS,
  parameter int TIMEOUT_SYMS = rx_ctrl_pkg::DEF_TIMEOUT_SYMS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sym_clk_ena,
  input  logic                          start,
  symbol_timing_search_if.master        acc,
  output logic [1:0]                    ds_del,
  output logic                          busy,
  output logic                          locked,
  output logic                          fail,
  output logic [ERR_W:0]                best_metric
);

  localparam logic [1:0]     LAST_PHASE = 2'(NUM_PHASES - 1);
  localparam logic [ERR_W:0] METRIC_MAX = '1;

  state_t         r_state, w_state_next;
  logic [1:0]     r_phase, r_best_phase, r_ds_del;
  logic [ERR_W:0] r_metric, r_best, r_best_metric;
  logic           r_phase_valid, r_best_valid;
  logic           r_busy, r_locked, r_fail, r_acc_clear;
  logic           w_settle_done, w_timeout;
  logic [ERR_W:0] w_sum;
  logic           w_take;
  logic [ERR_W:0] w_cmp_best;
  logic [1:0]     w_cmp_phase;
  logic           w_cmp_valid;

  sym_counter #(.TC(SETTLE_SYMS)) u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == S_SET_PHASE),
    .i_ena    ((r_state == S_SETTLE) && sym_clk_ena),
    .o_tc_hit (w_settle_done)
  );

  sym_counter #(.TC(TIMEOUT_SYMS)) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == S_CLEAR),
    .i_ena    ((r_state == S_MEASURE) && sym_clk_ena),
    .o_tc_hit (w_timeout)
  );

  // One extra bit so the I+Q sum can never wrap.
  assign w_sum = {1'b0, acc.acc_err_i} + {1'b0, acc.acc_err_q};

  // Strict less-than keeps the earlier (lower) phase on ties.
  assign w_take      = r_phase_valid && (!r_best_valid || (r_metric < r_best));
  assign w_cmp_best  = w_take ? r_metric : r_best;
  assign w_cmp_phase = w_take ? r_phase  : r_best_phase;
  assign w_cmp_valid = r_best_valid || r_phase_valid;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_LOCKED: if (start) w_state_next = S_SET_PHASE;
      S_SET_PHASE:      w_state_next = S_SETTLE;
      S_SETTLE:         if (w_settle_done) w_state_next = S_CLEAR;
      S_CLEAR:          w_state_next = S_MEASURE;
      S_MEASURE:        if (acc.acc_done || w_timeout) w_state_next = S_COMPARE;
      S_COMPARE: begin
        if (r_phase != LAST_PHASE) w_state_next = S_SET_PHASE;
        else if (w_cmp_valid)      w_state_next = S_LOCKED;
        else                       w_state_next = S_IDLE;
      end
      default:          w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase       <= '0;
      r_best_phase  <= '0;
      r_ds_del      <= '0;
      r_metric      <= '0;
      r_best        <= '0;
      r_best_metric <= '0;
      r_phase_valid <= 1'b0;
      r_best_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_locked      <= 1'b0;
      r_fail        <= 1'b0;
      r_acc_clear   <= 1'b0;
    end else begin
      // Registered so the pulse lines up exactly with the CLEAR state.
      r_acc_clear <= (w_state_next == S_CLEAR);
      case (r_state)
        S_IDLE, S_LOCKED: begin
          if (start) begin
            r_phase      <= '0;
            r_best_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
          end
        end
        S_SET_PHASE: r_ds_del <= r_phase;
        S_MEASURE: begin
          if (acc.acc_done) begin
            r_metric      <= w_sum;
            r_phase_valid <= 1'b1;
          end else if (w_timeout) begin
            r_metric      <= METRIC_MAX;
            r_phase_valid <= 1'b0;
          end
        end
        S_COMPARE: begin
          r_best       <= w_cmp_best;
          r_best_phase <= w_cmp_phase;
          r_best_valid <= w_cmp_valid;
          if (r_phase != LAST_PHASE) begin
            r_phase <= r_phase + 1'b1;
          end else if (w_cmp_valid) begin
            r_ds_del      <= w_cmp_phase;
            r_best_metric <= w_cmp_best;
            r_locked      <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_ds_del <= '0;
            r_fail   <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign acc.acc_clear = r_acc_clear;
  assign ds_del        = r_ds_del;
  assign busy          = r_busy;
  assign locked        = r_locked;
  assign fail          = r_fail;
  assign best_metric   = r_best_metric;

endmodule

// File: tb/tb_symbol_timing_search.sv
// tb/tb_symbol_timing_search.sv - directed bench for symbol_timing_search
module tb_symbol_timing_search;

  localparam int EW = 56;

  logic          clk = 1'b0;
  logic          reset;
  logic          sym_clk_ena;
  logic          start;
  logic [1:0]    ds_del;
  logic          busy, locked, fail;
  logic [EW:0]   best_metric;

  int checks = 0;
  int errors = 0;

  symbol_timing_search_if #(.ERR_W(EW)) acc_bus ();

  symbol_timing_search #(.ERR_W(EW), .SETTLE_SYMS(32), .TIMEOUT_SYMS(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_clk_ena (sym_clk_ena),
    .start       (start),
    .acc         (acc_bus.master),
    .ds_del      (ds_del),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .best_metric (best_metric)
  );

  always #5 clk = ~clk;

  // Accumulator model: after each acc_clear, answers rdelay[phase] symbols
  // later (0 = never) with ri/rq[phase]; optionally fires a bogus zero-error
  // acc_done during the clear cycle itself.
  int          rdelay [4];
  logic [EW-1:0] ri [4];
  logic [EW-1:0] rq [4];
  bit          inj_clear_done = 1'b0;
  int          plog [$];
  bit          armed = 1'b0;
  int          cnt = 0;
  int          ph = 0;

  initial begin
    sym_clk_ena       = 1'b0;
    acc_bus.acc_done  = 1'b0;
    acc_bus.acc_err_i = '0;
    acc_bus.acc_err_q = '0;
    forever begin
      @(negedge clk);
      sym_clk_ena      = ~sym_clk_ena;
      acc_bus.acc_done = 1'b0;
      if (reset === 1'b1) begin
        armed = 1'b0;
      end else if (acc_bus.acc_clear === 1'b1) begin
        ph    = int'(ds_del);
        armed = 1'b1;
        cnt   = 0;
        plog.push_back(ph);
        if (inj_clear_done) begin
          acc_bus.acc_done  = 1'b1;
          acc_bus.acc_err_i = '0;
          acc_bus.acc_err_q = '0;
        end
      end else if (armed && sym_clk_ena) begin
        cnt++;
        if (cnt == rdelay[ph]) begin
          acc_bus.acc_done  = 1'b1;
          acc_bus.acc_err_i = ri[ph];
          acc_bus.acc_err_q = rq[ph];
          armed = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  task automatic chk_sweep(input string tag);
    chk({tag, "_nclr"}, 64'(plog.size()), 64'd4);
    for (int i = 0; i < 4 && i < plog.size(); i++)
      chk($sformatf("%s_sweep%0d", tag, i), 64'(plog[i]), 64'(i));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ds_del"},    64'(ds_del),           64'd0);
    chk({tag, "_busy"},      64'(busy),             64'd0);
    chk({tag, "_locked"},    64'(locked),           64'd0);
    chk({tag, "_fail"},      64'(fail),             64'd0);
    chk({tag, "_best"},      64'(best_metric),      64'd0);
    chk({tag, "_acc_clear"}, 64'(acc_bus.acc_clear), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rdelay = '{8, 8, 8, 8};
    ri = '{56'd0, 56'd0, 56'd0, 56'd0};
    rq = '{56'd0, 56'd0, 56'd0, 56'd0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Basic sweep {900,300,700,500}; bogus acc_done in CLEAR and a start in SETTLE.
    ri = '{56'd600, 56'd100, 56'd350, 56'd250};
    rq = '{56'd300, 56'd200, 56'd350, 56'd250};
    inj_clear_done = 1'b1;
    plog.delete();
    pulse_start();
    chk("t1_busy_up", 64'(busy), 64'd1);
    chk("t1_locked_low", 64'(locked), 64'd0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t1_done");
    chk("t1_locked", 64'(locked), 64'd1);
    chk("t1_ds_del", 64'(ds_del), 64'd1);
    chk("t1_best", 64'(best_metric), 64'd300);
    chk("t1_fail", 64'(fail), 64'd0);
    chk_sweep("t1");
    inj_clear_done = 1'b0;

    // Restart from LOCKED, new minimum at phase 2.
    ri = '{56'd500, 56'd400, 56'd50, 56'd600};
    rq = '{56'd0, 56'd0, 56'd0, 56'd0};
    plog.delete();
    pulse_start();
    chk("t2_locked_drop", 64'(locked), 64'd0);
    chk("t2_busy_up", 64'(busy), 64'd1);
    wait_idle("t2_done");
    chk("t2_ds_del", 64'(ds_del), 64'd2);
    chk("t2_best", 64'(best_metric), 64'd50);
    chk_sweep("t2");

    // Tie between phases 1 and 2: lower phase wins.
    ri = '{56'd400, 56'd200, 56'd150, 56'd800};
    rq = '{56'd0, 56'd0, 56'd50, 56'd0};
    pulse_start();
    wait_idle("t3_done");
    chk("t3_ds_del", 64'(ds_del), 64'd1);
    chk("t3_best", 64'(best_metric), 64'd200);

    // Phase 2 times out.
    rdelay = '{8, 8, 0, 8};
    ri = '{56'd50, 56'd60, 56'd1, 56'd40};
    rq = '{56'd0, 56'd0, 56'd0, 56'd0};
    plog.delete();
    pulse_start();
    wait_idle("t4_done");
    chk("t4_ds_del", 64'(ds_del), 64'd3);
    chk("t4_best", 64'(best_metric), 64'd40);
    chk("t4_fail", 64'(fail), 64'd0);
    chk("t4_locked", 64'(locked), 64'd1);
    chk_sweep("t4");

    // acc_done on the final timeout enable: acc_done wins.
    rdelay = '{16, 16, 16, 16};
    ri = '{56'd70, 56'd30, 56'd90, 56'd80};
    pulse_start();
    wait_idle("t5_done");
    chk("t5_locked", 64'(locked), 64'd1);
    chk("t5_ds_del", 64'(ds_del), 64'd1);
    chk("t5_best", 64'(best_metric), 64'd30);

    // Full-width sums need the extra metric bit.
    rdelay = '{8, 8, 8, 8};
    ri = '{56'h80_0000_0000_0000, 56'hFF_FFFF_FFFF_FFFF, 56'hFF_FFFF_FFFF_FFFF, 56'h80_0000_0000_0001};
    rq = '{56'h80_0000_0000_0000, 56'd6, 56'hFF_FFFF_FFFF_FFFF, 56'h80_0000_0000_0000};
    pulse_start();
    wait_idle("t6_done");
    chk("t6_ds_del", 64'(ds_del), 64'd0);
    chk("t6_best", 64'(best_metric), 64'h0100_0000_0000_0000);

    // Nothing answers: fail.
    rdelay = '{0, 0, 0, 0};
    plog.delete();
    pulse_start();
    wait_idle("t7_done");
    chk("t7_fail", 64'(fail), 64'd1);
    chk("t7_locked", 64'(locked), 64'd0);
    chk("t7_ds_del", 64'(ds_del), 64'd0);
    chk("t7_nclr", 64'(plog.size()), 64'd4);

    // Reset during MEASURE of phase 2, then a clean full search.
    rdelay = '{8, 8, 8, 8};
    ri = '{56'd600, 56'd100, 56'd350, 56'd250};
    rq = '{56'd300, 56'd200, 56'd350, 56'd250};
    plog.delete();
    pulse_start();
    chk("t8_fail_cleared", 64'(fail), 64'd0);
    begin
      int n = 0;
      while (plog.size() < 3 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("t8_reach_ph2", 64'(n < 3000), 64'd1);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t8_rst");
    reset = 1'b0;
    plog.delete();
    repeat (150) @(negedge clk);
    chk("t8_no_clear", 64'(plog.size()), 64'd0);
    chk("t8_idle_busy", 64'(busy), 64'd0);
    pulse_start();
    wait_idle("t8_done");
    chk("t8_ds_del", 64'(ds_del), 64'd1);
    chk("t8_best", 64'(best_metric), 64'd300);
    chk("t8_locked", 64'(locked), 64'd1);
    chk_sweep("t8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
